// File: rtl/risc_v_pkg.sv
// Shared definitions for the multicycle RV32 control path: FSM state
// encoding, the opcodes the controller understands, and the ALUOp /
// ALU operand-B select codes driven towards the datapath.
package risc_v_pkg;

    // Controller states; codes 9..15 are unused and fall back to FETCH.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_BRANCH    = 4'd8
    } state_t;

    // Supported major opcodes (instr[6:0]).
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUOp codes consumed by the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand-B select codes.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // True for the states that wait on the memory ready handshake.
    function automatic logic is_mem_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM_READ) || (st == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: 8-bit saturating wait counter for memory handshakes.
// clear_i has priority over enable_i; expired_o is high once the count
// has reached MEM_TIMEOUT, i.e. after MEM_TIMEOUT cycles without ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle RV32 datapath.
// Sequences fetch/decode/execute/memory/writeback, drives all datapath
// strobes and selects, and aborts memory waits after MEM_TIMEOUT cycles.
// Optional macro MULTICYCLE_INSTRET_EN adds a retired-instruction counter
// output (instret, CNT_W bits).
module multicycle_control
    import risc_v_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_o
`ifdef MULTICYCLE_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    // Parameter sanity: the wait counter is 8 bits wide.
    if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255)) begin : g_bad_timeout
        $error("multicycle_control: MEM_TIMEOUT must be in 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multicycle_control: CNT_W must be at least 1");
    end

    state_t state_q;
    state_t state_d;

    logic in_wait;
    logic timer_expired;
    logic timeout;
    logic timer_clear;
    logic timer_enable;

    // A wait times out only if ready is still low in the expiry cycle;
    // a late ready completes the transfer normally.
    assign in_wait      = is_mem_wait_state(state_q);
    assign timeout      = in_wait && timer_expired && !mem_ready;
    // Clearing whenever the state changes (or on timeout, which may
    // re-enter FETCH from FETCH) means every wait state starts at zero.
    assign timer_clear  = !in_wait || (state_d != state_q) || timeout;
    assign timer_enable = in_wait && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clear),
        .enable_i (timer_enable),
        .expired_o(timer_expired)
    );

    // Next-state logic.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready)    state_d = ST_DECODE;
                else if (timeout) state_d = ST_FETCH;
                else              state_d = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:           state_d = ST_EXECUTE;
                    OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
                    OP_BRANCH:          state_d = ST_BRANCH;
                    default:            state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                state_d = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                if (mem_ready)    state_d = ST_MEM_WB;
                else if (timeout) state_d = ST_FETCH;
                else              state_d = ST_MEM_READ;
            end
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: begin
                if (mem_ready || timeout) state_d = ST_FETCH;
                else                      state_d = ST_MEM_WRITE;
            end
            ST_EXECUTE:   state_d = ST_ALU_WB;
            ST_ALU_WB:    state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode (FETCH loads are qualified by mem_ready); all
    // strobes and selects are forced low while reset is held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        ALUOp         = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Branch target is precomputed here for BRANCH to use.
                alu_src_b = SRCB_IMM;
                ALUOp     = ALUOP_ADD;
                if ((opcode != OP_RTYPE) && (opcode != OP_LOAD) &&
                    (opcode != OP_STORE) && (opcode != OP_BRANCH)) begin
                    illegal_instr = 1'b1;
                end
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ALUOp     = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RS2;
                ALUOp     = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RS2;
                ALUOp         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            default: begin
                // Unused encodings: everything stays low.
            end
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_RS2;
            ALUOp         = ALUOP_ADD;
            illegal_instr = 1'b0;
        end
    end

    assign bus_error = timeout && !reset;
    assign state_o   = state_q;

`ifdef MULTICYCLE_INSTRET_EN
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             retire;

    // An instruction retires on a normal return to FETCH; illegal and
    // timed-out returns are excluded.
    assign retire = (state_q == ST_MEM_WB) || (state_q == ST_ALU_WB) ||
                    (state_q == ST_BRANCH) ||
                    ((state_q == ST_MEM_WRITE) && mem_ready);

    // Next retired count, wrapping naturally at 2^CNT_W.
    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step drives inputs, pushes
// the expected {state, outputs} into a scoreboard queue, then pops and
// compares against what the controller shows in that cycle.
// Output vector layout (16 bits below the 4-bit state):
// [15]pc_write [14]pc_write_cond [13]pc_source [12]i_or_d [11]mem_read
// [10]mem_write [9]ir_write [8]mem_to_reg [7]reg_write [6]alu_src_a
// [5:4]alu_src_b [3:2]ALUOp [1]illegal_instr [0]bus_error
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read;
    logic       mem_write, ir_write, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, ALUOp;
    logic       illegal_instr, bus_error;
    logic [3:0] state_o;
`ifdef MULTICYCLE_INSTRET_EN
    logic [31:0] instret;
`endif

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];

    // States
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2,
                           S_MREAD = 4'd3, S_MWB = 4'd4, S_MWRITE = 4'd5,
                           S_EXEC = 4'd6, S_ALUWB = 4'd7, S_BRANCH = 4'd8;
    // Expected output patterns, written from the state table
    localparam logic [15:0] O_NONE     = 16'h0000;
    localparam logic [15:0] O_FETCH_W  = 16'h0810;
    localparam logic [15:0] O_FETCH_R  = 16'h8A10;
    localparam logic [15:0] O_FETCH_TO = 16'h0811;
    localparam logic [15:0] O_DECODE   = 16'h0020;
    localparam logic [15:0] O_DEC_ILL  = 16'h0022;
    localparam logic [15:0] O_MADDR    = 16'h0060;
    localparam logic [15:0] O_MREAD    = 16'h1800;
    localparam logic [15:0] O_MWB      = 16'h0180;
    localparam logic [15:0] O_MWRITE   = 16'h1400;
    localparam logic [15:0] O_MWR_TO   = 16'h1401;
    localparam logic [15:0] O_EXEC     = 16'h0048;
    localparam logic [15:0] O_ALUWB    = 16'h0080;
    localparam logic [15:0] O_BRANCH   = 16'h6044;

    localparam logic [6:0] R_OP = 7'b0110011, LW_OP = 7'b0000011,
                           SW_OP = 7'b0100011, BEQ_OP = 7'b1100011,
                           BAD_OP = 7'b1111111;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ALUOp(ALUOp), .illegal_instr(illegal_instr), .bus_error(bus_error),
        .state_o(state_o)
`ifdef MULTICYCLE_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    // One cycle: drive on the falling edge, check 1 ns later.
    task automatic step(input logic rst, input logic [6:0] op, input logic mr,
                        input logic [3:0] st, input logic [15:0] o,
                        input string tag);
        logic [19:0] got;
        logic [19:0] expv;
        @(negedge clk);
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        exp_q.push_back({st, o});
        #1;
        got = {state_o, pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, ALUOp, illegal_instr, bus_error};
        expv = exp_q.pop_front();
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: observed state=%0d out=%h expected state=%0d out=%h",
                   tag, got[19:16], got[15:0], expv[19:16], expv[15:0]);
        end
        $display("step %-12s state=%0d out=%h", tag, got[19:16], got[15:0]);
    endtask

`ifdef MULTICYCLE_INSTRET_EN
    task automatic check_instret(input logic [31:0] want, input string tag);
        total++;
        assert (instret === want) else begin
            bad++;
            $error("FAIL %s: observed instret=%0d expected %0d", tag, instret, want);
        end
    endtask
`endif

    initial begin
        // Reset state
        step(1'b1, R_OP, 1'b1, S_FETCH, O_NONE, "reset0");
        step(1'b1, R_OP, 1'b1, S_FETCH, O_NONE, "reset1");
`ifdef MULTICYCLE_INSTRET_EN
        check_instret(32'd0, "instret_rst");
`endif
        // R-type: 4 cycles
        step(1'b0, R_OP, 1'b1, S_FETCH,  O_FETCH_R, "r_fetch");
        step(1'b0, R_OP, 1'b1, S_DECODE, O_DECODE,  "r_decode");
        step(1'b0, R_OP, 1'b1, S_EXEC,   O_EXEC,    "r_exec");
        step(1'b0, R_OP, 1'b1, S_ALUWB,  O_ALUWB,   "r_aluwb");
        // lw with 3 wait cycles in MEM_READ
        step(1'b0, LW_OP, 1'b1, S_FETCH,  O_FETCH_R, "lw_fetch");
`ifdef MULTICYCLE_INSTRET_EN
        check_instret(32'd1, "instret_r");
`endif
        step(1'b0, LW_OP, 1'b1, S_DECODE, O_DECODE, "lw_decode");
        step(1'b0, LW_OP, 1'b0, S_MADDR,  O_MADDR,  "lw_maddr");
        for (int i = 0; i < 3; i++) step(1'b0, LW_OP, 1'b0, S_MREAD, O_MREAD, "lw_mread_w");
        step(1'b0, LW_OP, 1'b1, S_MREAD,  O_MREAD,  "lw_mread_r");
        step(1'b0, LW_OP, 1'b1, S_MWB,    O_MWB,    "lw_mwb");
        // beq: 3 cycles
        step(1'b0, BEQ_OP, 1'b1, S_FETCH,  O_FETCH_R, "beq_fetch");
`ifdef MULTICYCLE_INSTRET_EN
        check_instret(32'd2, "instret_lw");
`endif
        step(1'b0, BEQ_OP, 1'b1, S_DECODE, O_DECODE, "beq_decode");
        step(1'b0, BEQ_OP, 1'b1, S_BRANCH, O_BRANCH, "beq_branch");
        // Illegal opcode
        step(1'b0, BAD_OP, 1'b1, S_FETCH,  O_FETCH_R, "ill_fetch");
`ifdef MULTICYCLE_INSTRET_EN
        check_instret(32'd3, "instret_beq");
`endif
        step(1'b0, BAD_OP, 1'b1, S_DECODE, O_DEC_ILL, "ill_decode");
        // sw timing out: 15 wait cycles, bus_error on the 16th
        step(1'b0, SW_OP, 1'b1, S_FETCH,  O_FETCH_R, "swto_fetch");
        step(1'b0, SW_OP, 1'b1, S_DECODE, O_DECODE,  "swto_decode");
        step(1'b0, SW_OP, 1'b0, S_MADDR,  O_MADDR,   "swto_maddr");
        for (int i = 0; i < 15; i++) step(1'b0, SW_OP, 1'b0, S_MWRITE, O_MWRITE, "swto_wait");
        step(1'b0, SW_OP, 1'b0, S_MWRITE, O_MWR_TO,  "swto_expire");
        // sw with ready landing exactly in the timeout cycle
        step(1'b0, SW_OP, 1'b1, S_FETCH,  O_FETCH_R, "swlate_fetch");
`ifdef MULTICYCLE_INSTRET_EN
        check_instret(32'd3, "instret_ill_to");
`endif
        step(1'b0, SW_OP, 1'b1, S_DECODE, O_DECODE,  "swlate_dec");
        step(1'b0, SW_OP, 1'b0, S_MADDR,  O_MADDR,   "swlate_maddr");
        for (int i = 0; i < 15; i++) step(1'b0, SW_OP, 1'b0, S_MWRITE, O_MWRITE, "swlate_wait");
        step(1'b0, SW_OP, 1'b1, S_MWRITE, O_MWRITE,  "swlate_done");
        // Fetch timeout: re-fetch, no pc_write
        for (int i = 0; i < 15; i++) step(1'b0, SW_OP, 1'b0, S_FETCH, O_FETCH_W, "fto_wait");
`ifdef MULTICYCLE_INSTRET_EN
        check_instret(32'd4, "instret_sw");
`endif
        step(1'b0, SW_OP, 1'b0, S_FETCH,  O_FETCH_TO, "fto_expire");
        step(1'b0, SW_OP, 1'b0, S_FETCH,  O_FETCH_W,  "fto_restart");
        step(1'b0, SW_OP, 1'b1, S_FETCH,  O_FETCH_R,  "fto_fetch");
        // Reset while in MEM_WRITE
        step(1'b0, SW_OP, 1'b1, S_DECODE, O_DECODE,  "rstw_decode");
        step(1'b0, SW_OP, 1'b0, S_MADDR,  O_MADDR,   "rstw_maddr");
        step(1'b0, SW_OP, 1'b0, S_MWRITE, O_MWRITE,  "rstw_mwrite");
        step(1'b1, SW_OP, 1'b1, S_MWRITE, O_NONE,    "rstw_reset");
        step(1'b0, SW_OP, 1'b0, S_FETCH,  O_FETCH_W, "rstw_after");
`ifdef MULTICYCLE_INSTRET_EN
        check_instret(32'd0, "instret_rst2");
`endif
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_empty: observed %0d left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
